// File: rtl/branch_resolve_ex.sv
// rtl/branch_resolve_ex.sv - EX-stage branch resolution, redirect/flush FSM, training FIFO
// Optional statistics counters enabled by defining BRANCH_PERF_CNT_EN.
module branch_resolve_ex #(
  parameter int                          PC_WIDTH         = 8,
  parameter int                          DATA_WIDTH       = 32,
  parameter int                          ALU_OPCODE_WIDTH = 4,
  parameter logic [ALU_OPCODE_WIDTH-1:0] OP_BEQ           = 4'd8,
  parameter logic [ALU_OPCODE_WIDTH-1:0] OP_BNE           = 4'd9,
  parameter logic [ALU_OPCODE_WIDTH-1:0] OP_JMP           = 4'd10,
  parameter int                          FLUSH_CYCLES     = 2,
  parameter int                          CNT_WIDTH        = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [PC_WIDTH-1:0]         pc_in,
  input  logic [PC_WIDTH-1:0]         save_pc_in,
  input  logic [PC_WIDTH-1:0]         extended_addr_in,
  input  logic [DATA_WIDTH-1:0]       rd_data1_in,
  input  logic [DATA_WIDTH-1:0]       rd_data2_in,
  input  logic [ALU_OPCODE_WIDTH-1:0] alu_opcode_in,
  input  logic                        prediction_in,
  input  logic [DATA_WIDTH-1:0]       inst_in,
  output logic                        flush_out,
  output logic                        redirect_valid,
  output logic [PC_WIDTH-1:0]         redirect_pc,
  output logic                        train_valid,
  input  logic                        train_ready,
  output logic [PC_WIDTH-1:0]         train_pc,
  output logic                        train_taken,
  output logic                        train_mispred,
  output logic [CNT_WIDTH-1:0]        branch_count,
  output logic [CNT_WIDTH-1:0]        mispred_count,
  output logic [CNT_WIDTH-1:0]        train_drop_count
);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t              state_q, state_d;
  logic [2:0]          flush_cnt_q, flush_cnt_d;
  logic                flush_q, flush_d;
  logic                redirect_valid_q, redirect_valid_d;
  logic [PC_WIDTH-1:0] redirect_pc_q, redirect_pc_d;
  logic                is_branch_op, branch_valid, taken, mispred;

  logic [PC_WIDTH-1:0] fifo_pc_q [2];
  logic [PC_WIDTH-1:0] fifo_pc_d [2];
  logic [1:0]          fifo_taken_q, fifo_taken_d;
  logic [1:0]          fifo_mis_q, fifo_mis_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic [1:0]          count_q, count_d;
  logic                pop, push_ok, wr_ptr;

  always_comb begin
    is_branch_op = (alu_opcode_in == OP_BEQ) || (alu_opcode_in == OP_BNE) ||
                   (alu_opcode_in == OP_JMP);
    branch_valid = (inst_in != '0) && is_branch_op && (state_q == IDLE);
    taken = 1'b1;
    if (alu_opcode_in == OP_BEQ)      taken = (rd_data1_in == rd_data2_in);
    else if (alu_opcode_in == OP_BNE) taken = (rd_data1_in != rd_data2_in);
    mispred = branch_valid && (taken != prediction_in);
  end

  always_comb begin
    state_d          = state_q;
    flush_cnt_d      = flush_cnt_q;
    flush_d          = flush_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    case (state_q)
      IDLE: begin
        if (mispred) begin
          state_d          = FLUSH;
          flush_d          = 1'b1;
          redirect_valid_d = 1'b1;
          redirect_pc_d    = prediction_in ? save_pc_in : extended_addr_in;
          flush_cnt_d      = 3'(FLUSH_CYCLES - 1);
        end
      end
      FLUSH: begin
        if (flush_cnt_q == '0) begin
          state_d = IDLE;
          flush_d = 1'b0;
        end else begin
          flush_cnt_d = flush_cnt_q - 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A pop frees the head slot first, so a full FIFO can accept a push in the same cycle.
  always_comb begin
    fifo_pc_d    = fifo_pc_q;
    fifo_taken_d = fifo_taken_q;
    fifo_mis_d   = fifo_mis_q;
    pop          = (count_q != 2'd0) && train_ready;
    push_ok      = branch_valid && ((count_q != 2'd2) || pop);
    wr_ptr       = rd_ptr_q ^ count_q[0];
    if (push_ok) begin
      fifo_pc_d[wr_ptr]    = pc_in;
      fifo_taken_d[wr_ptr] = taken;
      fifo_mis_d[wr_ptr]   = mispred;
    end
    rd_ptr_d = rd_ptr_q ^ pop;
    count_d  = 2'(count_q + {1'b0, push_ok} - {1'b0, pop});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      flush_cnt_q      <= '0;
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      fifo_pc_q        <= '{default: '0};
      fifo_taken_q     <= '0;
      fifo_mis_q       <= '0;
      rd_ptr_q         <= 1'b0;
      count_q          <= '0;
    end else begin
      state_q          <= state_d;
      flush_cnt_q      <= flush_cnt_d;
      flush_q          <= flush_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      fifo_pc_q        <= fifo_pc_d;
      fifo_taken_q     <= fifo_taken_d;
      fifo_mis_q       <= fifo_mis_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
    end
  end

  assign flush_out      = flush_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign train_valid    = (count_q != 2'd0);
  assign train_pc       = fifo_pc_q[rd_ptr_q];
  assign train_taken    = fifo_taken_q[rd_ptr_q];
  assign train_mispred  = fifo_mis_q[rd_ptr_q];

`ifdef BRANCH_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_WIDTH-1:0] mis_cnt_q, mis_cnt_d;
  logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
  logic                 drop;

  // Counters saturate at all-ones rather than wrapping.
  always_comb begin
    branch_cnt_d = branch_cnt_q;
    mis_cnt_d    = mis_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    drop         = branch_valid && !push_ok;
    if (branch_valid && (branch_cnt_q != '1)) branch_cnt_d = branch_cnt_q + 1'b1;
    if (mispred && (mis_cnt_q != '1))         mis_cnt_d    = mis_cnt_q + 1'b1;
    if (drop && (drop_cnt_q != '1))           drop_cnt_d   = drop_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      branch_cnt_q <= '0;
      mis_cnt_q    <= '0;
      drop_cnt_q   <= '0;
    end else begin
      branch_cnt_q <= branch_cnt_d;
      mis_cnt_q    <= mis_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign branch_count     = branch_cnt_q;
  assign mispred_count    = mis_cnt_q;
  assign train_drop_count = drop_cnt_q;
`else
  assign branch_count     = '0;
  assign mispred_count    = '0;
  assign train_drop_count = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_ex.sv
// tb/tb_branch_resolve_ex.sv - directed bench with a queue-based reference model
module tb_branch_resolve_ex;

`ifdef BRANCH_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  pc_in, save_pc_in, extended_addr_in;
  logic [31:0] rd_data1_in, rd_data2_in, inst_in;
  logic [3:0]  alu_opcode_in;
  logic        prediction_in, train_ready;

  logic        flush_out, redirect_valid, train_valid, train_taken, train_mispred;
  logic [7:0]  redirect_pc, train_pc;
  logic [15:0] branch_count, mispred_count, train_drop_count;

  logic        s_flush, s_rv, s_tv, s_tt, s_tm;
  logic [7:0]  s_rpc, s_tpc;
  logic [1:0]  s_bc, s_mc, s_dc;

  always #5 clk = ~clk;

  branch_resolve_ex dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .save_pc_in(save_pc_in),
    .extended_addr_in(extended_addr_in), .rd_data1_in(rd_data1_in), .rd_data2_in(rd_data2_in),
    .alu_opcode_in(alu_opcode_in), .prediction_in(prediction_in), .inst_in(inst_in),
    .flush_out(flush_out), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .train_valid(train_valid), .train_ready(train_ready), .train_pc(train_pc),
    .train_taken(train_taken), .train_mispred(train_mispred), .branch_count(branch_count),
    .mispred_count(mispred_count), .train_drop_count(train_drop_count)
  );

  branch_resolve_ex #(.CNT_WIDTH(2)) dut_small (
    .clk(clk), .reset(reset), .pc_in(pc_in), .save_pc_in(save_pc_in),
    .extended_addr_in(extended_addr_in), .rd_data1_in(rd_data1_in), .rd_data2_in(rd_data2_in),
    .alu_opcode_in(alu_opcode_in), .prediction_in(prediction_in), .inst_in(inst_in),
    .flush_out(s_flush), .redirect_valid(s_rv), .redirect_pc(s_rpc),
    .train_valid(s_tv), .train_ready(train_ready), .train_pc(s_tpc),
    .train_taken(s_tt), .train_mispred(s_tm), .branch_count(s_bc),
    .mispred_count(s_mc), .train_drop_count(s_dc)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit started = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int m;
    m = (1 << w) - 1;
    return (v > m) ? m : v;
  endfunction

  // Reference model: records in a queue, flush as a remaining-cycle count.
  typedef struct {
    logic [7:0] pc;
    bit         taken;
    bit         mis;
  } rec_t;

  rec_t        mq[$];
  int          flush_left = 0;
  bit          e_rv = 1'b0;
  logic [7:0]  e_rpc = '0;
  int          bcnt = 0, mcnt = 0, dcnt = 0;
  bit          m_in_flush, m_pop, m_valid, m_taken, m_mis;

  always begin
    @(posedge clk);
    if (reset) begin
      mq.delete();
      flush_left = 0; e_rv = 1'b0; e_rpc = '0;
      bcnt = 0; mcnt = 0; dcnt = 0;
    end else begin
      e_rv       = 1'b0;
      m_in_flush = (flush_left > 0);
      if (m_in_flush) flush_left--;
      m_pop   = (mq.size() > 0) && train_ready;
      m_valid = (inst_in != 0) && (alu_opcode_in inside {4'd8, 4'd9, 4'd10}) && !m_in_flush;
      if (m_pop) void'(mq.pop_front());
      if (m_valid) begin
        if (alu_opcode_in == 4'd8)      m_taken = (rd_data1_in == rd_data2_in);
        else if (alu_opcode_in == 4'd9) m_taken = (rd_data1_in != rd_data2_in);
        else                            m_taken = 1'b1;
        m_mis = (m_taken != prediction_in);
        bcnt++;
        if (m_mis) mcnt++;
        if (mq.size() < 2) mq.push_back('{pc: pc_in, taken: m_taken, mis: m_mis});
        else dcnt++;
        if (m_mis) begin
          flush_left = FC;
          e_rv  = 1'b1;
          e_rpc = prediction_in ? save_pc_in : extended_addr_in;
        end
      end
    end
  end

  always begin
    @(negedge clk);
    if (started) begin
      check("flush_out", flush_out, flush_left > 0);
      check("redirect_valid", redirect_valid, e_rv);
      if (e_rv) check("redirect_pc", redirect_pc, e_rpc);
      check("train_valid", train_valid, mq.size() > 0);
      if (mq.size() > 0) begin
        check("train_pc", train_pc, mq[0].pc);
        check("train_taken", train_taken, mq[0].taken);
        check("train_mispred", train_mispred, mq[0].mis);
      end
      check("branch_count", branch_count, PERF ? sat(bcnt, 16) : 0);
      check("mispred_count", mispred_count, PERF ? sat(mcnt, 16) : 0);
      check("train_drop_count", train_drop_count, PERF ? sat(dcnt, 16) : 0);
      check("small_flush_out", s_flush, flush_left > 0);
      check("small_branch_count", s_bc, PERF ? sat(bcnt, 2) : 0);
      check("small_mispred_count", s_mc, PERF ? sat(mcnt, 2) : 0);
      check("small_drop_count", s_dc, PERF ? sat(dcnt, 2) : 0);
    end
  end

  task automatic br(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                    input logic pred, input logic [7:0] pc, input logic [7:0] tgt);
    @(negedge clk);
    alu_opcode_in    = op;
    rd_data1_in      = a;
    rd_data2_in      = b;
    prediction_in    = pred;
    pc_in            = pc;
    save_pc_in       = pc + 8'd1;
    extended_addr_in = tgt;
    inst_in          = 32'h1234_0000 | {24'd0, pc};
  endtask

  task automatic bubble();
    @(negedge clk);
    inst_in       = '0;
    alu_opcode_in = '0;
  endtask

  initial begin
    reset = 1'b1; train_ready = 1'b1;
    pc_in = '0; save_pc_in = '0; extended_addr_in = '0;
    rd_data1_in = '0; rd_data2_in = '0; alu_opcode_in = '0;
    prediction_in = 1'b0; inst_in = '0;
    @(posedge clk);
    @(negedge clk);
    started = 1'b1;
    check("lit_reset_flush", flush_out, 0);
    check("lit_reset_train_valid", train_valid, 0);
    reset = 1'b0;

    // Correctly predicted BEQ.
    br(4'd8, 32'd5, 32'd5, 1'b1, 8'h10, 8'h90);
    bubble();
    check("lit_t1_flush", flush_out, 0);
    check("lit_t1_train_valid", train_valid, 1);
    check("lit_t1_train_taken", train_taken, 1);
    check("lit_t1_train_mispred", train_mispred, 0);
    check("lit_t1_branch_count", branch_count, PERF ? 1 : 0);
    bubble();

    // BNE predicted taken but not taken: redirect to fall-through.
    br(4'd9, 32'd7, 32'd7, 1'b1, 8'h20, 8'h50);
    bubble();
    check("lit_t2_redirect_valid", redirect_valid, 1);
    check("lit_t2_redirect_pc", redirect_pc, 8'h21);
    check("lit_t2_flush_c1", flush_out, 1);
    bubble();
    check("lit_t2_flush_c2", flush_out, 1);
    check("lit_t2_redirect_drop", redirect_valid, 0);
    bubble();
    check("lit_t2_flush_end", flush_out, 0);
    check("lit_t2_mispred_count", mispred_count, PERF ? 1 : 0);

    // JMP predicted not taken, then a wrong-path BEQ during the flush.
    br(4'd10, 32'd0, 32'd1, 1'b0, 8'h30, 8'h40);
    br(4'd8, 32'd1, 32'd1, 1'b0, 8'h35, 8'h77);
    check("lit_t3_redirect_pc", redirect_pc, 8'h40);
    bubble();
    bubble();
    check("lit_t3_flush_end", flush_out, 0);
    check("lit_t3_branch_count", branch_count, PERF ? 3 : 0);

    // Back-pressure: fill the FIFO, drop the third, then push+pop while full.
    train_ready = 1'b0;
    br(4'd8, 32'd1, 32'd1, 1'b1, 8'h60, 8'h00);
    br(4'd9, 32'd1, 32'd2, 1'b1, 8'h61, 8'h00);
    br(4'd10, 32'd0, 32'd0, 1'b1, 8'h62, 8'h00);
    bubble();
    check("lit_t4_head", train_pc, 8'h60);
    check("lit_t4_drop", train_drop_count, PERF ? 1 : 0);
    bubble();
    bubble();
    check("lit_t4_head_stable", train_pc, 8'h60);
    br(4'd8, 32'd4, 32'd4, 1'b1, 8'h63, 8'h00);
    train_ready = 1'b1;
    bubble();
    check("lit_t4_head_after_pop", train_pc, 8'h61);
    bubble();
    check("lit_t4_head_pushed", train_pc, 8'h63);
    bubble();
    check("lit_t4_empty", train_valid, 0);

    // Reset on the first flush cycle.
    train_ready = 1'b0;
    br(4'd8, 32'd1, 32'd2, 1'b1, 8'h70, 8'h00);
    bubble();
    check("lit_t5_flush_before", flush_out, 1);
    reset = 1'b1;
    @(negedge clk);
    check("lit_t5_flush", flush_out, 0);
    check("lit_t5_train_valid", train_valid, 0);
    check("lit_t5_branch_count", branch_count, 0);
    check("lit_t5_mispred_count", mispred_count, 0);
    reset = 1'b0;
    train_ready = 1'b1;

    // Five correct branches: the 2-bit counter saturates at 3.
    for (int i = 0; i < 5; i++) br(4'd8, 32'd3, 32'd3, 1'b1, 8'h80 + 8'(i), 8'h00);
    bubble();
    bubble();
    bubble();
    check("lit_t6_branch_count", branch_count, PERF ? 5 : 0);
    check("lit_t6_small_sat", s_bc, PERF ? 3 : 0);

    @(negedge clk);
    started = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
